// File: rtl/multi_vc_buffer.sv
// Multi-virtual-channel input buffer: VC_NUM circular FIFOs sharing one storage block, with per-VC credit return.
// Optional sticky error flags per VC are enabled by defining MULTI_VC_BUFFER_ERR_CHECK_EN.
module multi_vc_buffer #(
  parameter int VC_NUM      = 2,
  parameter int BUFFER_SIZE = 8,
  parameter int FLIT_SIZE   = 8,
  localparam int VC_W       = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 write_i,
  input  logic [VC_W-1:0]      write_vc_i,
  input  logic [FLIT_SIZE-1:0] data_i,
  input  logic                 read_i,
  input  logic [VC_W-1:0]      read_vc_i,
  output logic [FLIT_SIZE-1:0] data_o,
  output logic [VC_NUM-1:0]    is_full_o,
  output logic [VC_NUM-1:0]    is_empty_o,
  output logic [VC_NUM-1:0]    credit_o
`ifdef MULTI_VC_BUFFER_ERR_CHECK_EN
  ,
  output logic [VC_NUM-1:0]    error_o
`endif
);

  localparam int PTR_W = $clog2(BUFFER_SIZE);
  localparam int CNT_W = $clog2(BUFFER_SIZE + 1);

  logic [PTR_W-1:0]     rd_ptr [VC_NUM];
  logic [PTR_W-1:0]     wr_ptr [VC_NUM];
  logic [CNT_W-1:0]     cnt    [VC_NUM];
  logic [FLIT_SIZE-1:0] mem    [VC_NUM][BUFFER_SIZE];

  logic [VC_NUM-1:0] full, empty;
  logic [VC_NUM-1:0] rd_req, wr_req, rd_en, wr_en;
  logic [VC_NUM-1:0] credit_p0;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUFFER_SIZE - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Selects that match no VC index produce no request on any VC.
  always_comb begin
    full   = '0;
    empty  = '0;
    rd_req = '0;
    wr_req = '0;
    rd_en  = '0;
    wr_en  = '0;
    data_o = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      full[v]   = (cnt[v] == CNT_W'(BUFFER_SIZE));
      empty[v]  = (cnt[v] == '0);
      rd_req[v] = read_i  && (read_vc_i  == VC_W'(v));
      wr_req[v] = write_i && (write_vc_i == VC_W'(v));
      rd_en[v]  = rd_req[v] && !empty[v];
      wr_en[v]  = wr_req[v] && (!full[v] || rd_en[v]);
      if ((read_vc_i == VC_W'(v)) && !empty[v])
        data_o = mem[v][rd_ptr[v]];
    end
  end

  assign is_full_o  = full;
  assign is_empty_o = empty;
  assign credit_o   = credit_p0;

  // Stage p0: pointer/count update and credit register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int v = 0; v < VC_NUM; v++) begin
        rd_ptr[v] <= '0;
        wr_ptr[v] <= '0;
        cnt[v]    <= '0;
      end
      credit_p0 <= '0;
    end else begin
      credit_p0 <= rd_en;
      for (int v = 0; v < VC_NUM; v++) begin
        if (rd_en[v]) rd_ptr[v] <= ptr_next(rd_ptr[v]);
        if (wr_en[v]) wr_ptr[v] <= ptr_next(wr_ptr[v]);
        if (wr_en[v] && !rd_en[v])
          cnt[v] <= cnt[v] + CNT_W'(1);
        else if (rd_en[v] && !wr_en[v])
          cnt[v] <= cnt[v] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int v = 0; v < VC_NUM; v++)
      if (wr_en[v]) mem[v][wr_ptr[v]] <= data_i;
  end

`ifdef MULTI_VC_BUFFER_ERR_CHECK_EN
  logic [VC_NUM-1:0] err_flag;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      err_flag <= '0;
    else
      err_flag <= err_flag | (wr_req & ~wr_en) | (rd_req & ~rd_en);
  end

  assign error_o = err_flag;
`endif

endmodule

// File: tb/tb_multi_vc_buffer.sv
// Directed table-driven bench for multi_vc_buffer (depth 8 and depth 5 instances, two VCs).
module tb_multi_vc_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       write_i = 1'b0;
  logic       write_vc_i = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       read_i = 1'b0;
  logic       read_vc_i = 1'b0;

  logic [7:0] data8, data5;
  logic [1:0] full8, empty8, cred8;
  logic [1:0] full5, empty5, cred5;
`ifdef MULTI_VC_BUFFER_ERR_CHECK_EN
  logic [1:0] err8, err5;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  multi_vc_buffer #(.VC_NUM(2), .BUFFER_SIZE(8), .FLIT_SIZE(8)) dut8 (
    .clk        (clk),
    .rst        (rst),
    .write_i    (write_i),
    .write_vc_i (write_vc_i),
    .data_i     (data_i),
    .read_i     (read_i),
    .read_vc_i  (read_vc_i),
    .data_o     (data8),
    .is_full_o  (full8),
    .is_empty_o (empty8),
    .credit_o   (cred8)
`ifdef MULTI_VC_BUFFER_ERR_CHECK_EN
    ,
    .error_o    (err8)
`endif
  );

  multi_vc_buffer #(.VC_NUM(2), .BUFFER_SIZE(5), .FLIT_SIZE(8)) dut5 (
    .clk        (clk),
    .rst        (rst),
    .write_i    (write_i),
    .write_vc_i (write_vc_i),
    .data_i     (data_i),
    .read_i     (read_i),
    .read_vc_i  (read_vc_i),
    .data_o     (data5),
    .is_full_o  (full5),
    .is_empty_o (empty5),
    .credit_o   (cred5)
`ifdef MULTI_VC_BUFFER_ERR_CHECK_EN
    ,
    .error_o    (err5)
`endif
  );

  typedef struct {
    logic       wr;
    logic       wvc;
    logic [7:0] din;
    logic       rd;
    logic       rvc;
    logic [7:0] xdata;
    logic [1:0] xfull;
    logic [1:0] xempty;
    logic [1:0] xcred;
    logic [1:0] xerr;
    logic       d5;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s[%0d]: got %0h want %0h", nm, idx, act, exp);
    else
      passed++;
  endtask

  task automatic add(input logic wr, input logic wvc, input logic [7:0] din,
                     input logic rd, input logic rvc, input logic [7:0] xdata,
                     input logic [1:0] xfull, input logic [1:0] xempty,
                     input logic [1:0] xcred, input logic [1:0] xerr, input logic d5);
    vec_t v;
    v.wr = wr; v.wvc = wvc; v.din = din; v.rd = rd; v.rvc = rvc;
    v.xdata = xdata; v.xfull = xfull; v.xempty = xempty; v.xcred = xcred;
    v.xerr = xerr; v.d5 = d5;
    vq.push_back(v);
  endtask

  // Each vector: drive at posedge+1, check data_o at negedge, flags/credit at next posedge+1.
  task automatic run_table();
    foreach (vq[i]) begin
      write_i = vq[i].wr; write_vc_i = vq[i].wvc; data_i = vq[i].din;
      read_i  = vq[i].rd; read_vc_i  = vq[i].rvc;
      @(negedge clk);
      check("data_o", i, vq[i].d5 ? data5 : data8, vq[i].xdata);
      @(posedge clk);
      #1;
      check("full", i, vq[i].d5 ? full5 : full8, vq[i].xfull);
      check("empty", i, vq[i].d5 ? empty5 : empty8, vq[i].xempty);
      check("credit", i, vq[i].d5 ? cred5 : cred8, vq[i].xcred);
`ifdef MULTI_VC_BUFFER_ERR_CHECK_EN
      if (!vq[i].d5) check("error", i, err8, vq[i].xerr);
`endif
      write_i = 1'b0;
      read_i  = 1'b0;
    end
    vq.delete();
  endtask

  initial begin
    #2;
    check("rst_empty8", 0, empty8, 2'b11);
    check("rst_full8", 0, full8, 2'b00);
    check("rst_cred8", 0, cred8, 2'b00);
    check("rst_data8", 0, data8, 8'h00);
    check("rst_empty5", 0, empty5, 2'b11);
`ifdef MULTI_VC_BUFFER_ERR_CHECK_EN
    check("rst_err8", 0, err8, 2'b00);
`endif
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Depth-8 instance: overfill, drain, full read+write, interleave.
    for (int i = 0; i < 10; i++)
      add(1, 0, 8'h10 + 8'(i), 0, 0, (i == 0) ? 8'h00 : 8'h10,
          (i >= 7) ? 2'b01 : 2'b00, 2'b10, 2'b00, (i >= 8) ? 2'b01 : 2'b00, 0);
    for (int i = 0; i < 9; i++)
      add(0, 0, 8'h00, 1, 0, (i < 8) ? 8'h10 + 8'(i) : 8'h00,
          2'b00, (i >= 7) ? 2'b11 : 2'b10, (i < 8) ? 2'b01 : 2'b00, 2'b01, 0);
    for (int i = 0; i < 8; i++)
      add(1, 1, 8'h30 + 8'(i), 0, 1, (i == 0) ? 8'h00 : 8'h30,
          (i == 7) ? 2'b10 : 2'b00, 2'b01, 2'b00, 2'b01, 0);
    for (int i = 0; i < 4; i++)
      add(1, 1, 8'hA0 + 8'(i), 1, 1, 8'h30 + 8'(i), 2'b10, 2'b01, 2'b10, 2'b01, 0);
    for (int i = 0; i < 8; i++)
      add(0, 0, 8'h00, 1, 1, (i < 4) ? 8'h34 + 8'(i) : 8'hA0 + 8'(i - 4),
          2'b00, (i == 7) ? 2'b11 : 2'b01, 2'b10, 2'b01, 0);
    for (int i = 0; i < 8; i++)
      add(1, 1, 8'h40 + 8'(i), 0, 1, (i == 0) ? 8'h00 : 8'h40,
          (i == 7) ? 2'b10 : 2'b00, 2'b01, 2'b00, 2'b01, 0);
    for (int i = 0; i < 12; i++)
      add(1, 0, 8'h60 + 8'(i), 1, 1, (i < 8) ? 8'h40 + 8'(i) : 8'h00,
          (i >= 7) ? 2'b01 : 2'b00, (i >= 7) ? 2'b10 : 2'b00,
          (i < 8) ? 2'b10 : 2'b00, (i >= 8) ? 2'b11 : 2'b01, 0);
    for (int i = 0; i < 8; i++)
      add(0, 0, 8'h00, 1, 0, 8'h60 + 8'(i), 2'b00, (i == 7) ? 2'b11 : 2'b10,
          2'b01, 2'b11, 0);
    run_table();

    // Same-VC read+write on an empty VC: write lands, no credit, no bypass.
    write_i = 1'b1; write_vc_i = 1'b0; data_i = 8'hB5; read_i = 1'b1; read_vc_i = 1'b0;
    @(negedge clk);
    check("rw_empty_data_pre", 0, data8, 8'h00);
    @(posedge clk);
    #1;
    write_i = 1'b0; read_i = 1'b0;
    check("rw_empty_cred", 0, cred8, 2'b00);
    check("rw_empty_flag", 0, empty8, 2'b10);
    check("rw_empty_data_post", 0, data8, 8'hB5);
    read_i = 1'b1;
    @(posedge clk);
    #1;
    read_i = 1'b0;
    check("rw_empty_drain_cred", 0, cred8, 2'b01);
    check("rw_empty_drain_flag", 0, empty8, 2'b11);

    // Asynchronous reset with three flits buffered and a credit pulse in flight.
    for (int i = 0; i < 3; i++) begin
      write_i = 1'b1; write_vc_i = 1'b0; data_i = 8'hC0 + 8'(i);
      @(posedge clk);
      #1;
    end
    write_i = 1'b0;
    read_i = 1'b1; read_vc_i = 1'b0;
    @(posedge clk);
    #1;
    check("pre_rst_cred", 0, cred8, 2'b01);
    check("pre_rst_data", 0, data8, 8'hC1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_empty", 0, empty8, 2'b11);
    check("async_rst_full", 0, full8, 2'b00);
    check("async_rst_cred", 0, cred8, 2'b00);
    check("async_rst_data", 0, data8, 8'h00);
`ifdef MULTI_VC_BUFFER_ERR_CHECK_EN
    check("async_rst_err", 0, err8, 2'b00);
`endif
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_data", 0, data8, 8'h00);
    @(posedge clk);
    #1;
    read_i = 1'b0;
    check("post_rst_cred", 0, cred8, 2'b00);

    // Depth-5 instance: pointer wrap on a non-power-of-two depth.
    for (int i = 0; i < 5; i++)
      add(1, 1, 8'h50 + 8'(i), 0, 1, (i == 0) ? 8'h00 : 8'h50,
          (i == 4) ? 2'b10 : 2'b00, 2'b01, 2'b00, 2'b00, 1);
    for (int i = 0; i < 3; i++)
      add(0, 0, 8'h00, 1, 1, 8'h50 + 8'(i), 2'b00, 2'b01, 2'b10, 2'b00, 1);
    for (int i = 0; i < 3; i++)
      add(1, 1, 8'h55 + 8'(i), 0, 1, 8'h53, (i == 2) ? 2'b10 : 2'b00, 2'b01, 2'b00, 2'b00, 1);
    for (int i = 0; i < 12; i++)
      add(1, 0, 8'h60 + 8'(i), 1, 1, (i < 5) ? 8'h53 + 8'(i) : 8'h00,
          (i >= 4) ? 2'b01 : 2'b00, (i >= 4) ? 2'b10 : 2'b00,
          (i < 5) ? 2'b10 : 2'b00, 2'b00, 1);
    for (int i = 0; i < 6; i++)
      add(0, 0, 8'h00, 1, 0, (i < 5) ? 8'h60 + 8'(i) : 8'h00, 2'b00,
          (i >= 4) ? 2'b11 : 2'b10, (i < 5) ? 2'b01 : 2'b00, 2'b00, 1);
    run_table();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/multi_vc_buffer.md
# multi_vc_buffer

Multi-virtual-channel input buffer for the router input port: `VC_NUM` independent circular FIFOs of `BUFFER_SIZE` flits each, sharing one storage block, one write port and one read port. Upstream writes a flit into the VC named by `write_vc_i`. The switch-allocation stage reads the head flit of the VC named by `read_vc_i`. Each dequeue returns a one-cycle credit pulse per VC to the upstream link.

## Interface
- `VC_NUM`, 2: number of virtual channels, ≥1; `VC_W = max(1, $clog2(VC_NUM))`
- `BUFFER_SIZE`, 8: flits per VC, ≥2, any integer (power of two not required)
- `FLIT_SIZE`, 8: flit width in bits
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `write_i`  in  1  write request
- `write_vc_i`  in  VC_W  target VC of the write
- `data_i`  in  FLIT_SIZE  flit to write
- `read_i`  in  1  read (dequeue) request
- `read_vc_i`  in  VC_W  VC to read
- `data_o`  out  FLIT_SIZE  head flit of VC `read_vc_i`; combinational
- `is_full_o`  out  VC_NUM  bit v = VC v holds BUFFER_SIZE flits
- `is_empty_o`  out  VC_NUM  bit v = VC v holds 0 flits
- `credit_o`  out  VC_NUM  registered one-cycle pulse per dequeued flit

## Operation
- Per-VC state: `rd_ptr`, `wr_ptr` (`$clog2(BUFFER_SIZE)` bits), `count` (`$clog2(BUFFER_SIZE+1)` bits).
- Pointers wrap explicitly: `BUFFER_SIZE-1` → 0. Never rely on natural overflow.
- Effective read: `read_i && !empty[read_vc_i]`. It advances `rd_ptr` and decrements `count` of that VC.
- Effective write: `write_i && (!full[write_vc_i] || rd_same)`, where `rd_same` = effective read on the same VC in the same cycle. It stores `data_i` at `wr_ptr`, advances `wr_ptr` and increments `count`.
- Write to a full VC with no same-VC read: dropped; no state change.
- Read from an empty VC: ignored, no credit.
- Same-VC read+write while full: both performed; `count` stays `BUFFER_SIZE`; the new flit lands in the freed slot.
- Same-VC read+write while empty: only the write takes effect (no bypass). `is_empty_o[v]` drops after the edge.
- Read and write on different VCs: fully independent.
- `VC_W`-wide selects ≥ `VC_NUM`: treated as no request.
- `data_o` = `memory[read_vc_i][rd_ptr]` when that VC is non-empty, else 0. It does not depend on `read_i`.
- `is_full_o`/`is_empty_o` decode from `count`.

## Timing
- Reset (`rst`=0, asynchronous):
  - all pointers and counts cleared
  - `is_empty_o` = all ones, `is_full_o` = 0, `credit_o` = 0, `data_o` = 0
  - memory contents are not reset
- Reset mid-operation discards all flits immediately. Pending credits are lost; upstream is re-initialised by the same reset.
- Write latency: a flit written at edge N appears on `data_o` (if at head) and is reflected in the flags right after edge N.
- Read: `data_o` is valid in the same cycle `read_i` is asserted. The dequeue takes effect at the edge.
- Credit: effective read on VC v at edge N → `credit_o[v]` = 1 for the cycle after edge N. Back-to-back reads give back-to-back pulses.

## Configuration
- `MULTI_VC_BUFFER_ERR_CHECK_EN` defined:
  - adds output `error_o`, width `VC_NUM`
  - bit v is a sticky flag, set at the edge of a dropped write to VC v or an ignored read of VC v
  - cleared only by reset; reset value 0
- Undefined: port `error_o` and its logic are absent; dropped/ignored requests are silent.

## Test plan
- Reset, then 10 writes to VC0 (data 0x10..0x19): `is_full_o[0]`=1 after the 8th write; writes 9–10 dropped; `is_empty_o[1]`=1 throughout; `error_o[0]`=1 if the macro is enabled.
- Read VC0 ×9: `data_o` = 0x10..0x17 in order, eight `credit_o[0]` pulses, `is_empty_o[0]`=1 after the 8th read; 9th read gives no credit and `data_o`=0.
- Fill VC1 with 8 flits, then same-cycle read+write of VC1 for 4 cycles (new data 0xA0..0xA3): `is_full_o[1]` stays 1; subsequent drain yields the last 4 original flits then 0xA0..0xA3.
- Interleave: write VC0 while reading VC1 each cycle for 12 cycles: counts are independent, no cross-VC corruption, pointers wrap correctly (also run with `BUFFER_SIZE`=5).
- Same-VC read+write while empty: write accepted, no credit; `data_o` shows the flit next cycle.
- Assert `rst`=0 asynchronously mid-burst with 3 flits buffered: flags go to empty immediately, without waiting for a clock edge; `credit_o`=0; subsequent reads return 0.
